// File: rtl/dsp_seq_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: opmodes, stage offsets
// and datapath widths.
package dsp_seq_pkg;

    localparam int OP_W  = 18;
    localparam int RES_W = 48;

    // X=M, Z=0: first beat of a vector discards the previous P.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    // X=M, Z=P: accumulate onto the running sum.
    localparam logic [7:0] OPM_ACC   = 8'h09;

    // Offsets from the issue cycle (dsp_a/dsp_b driven) to each action.
    localparam int OPM_OFS = 1;
    localparam int CEP_OFS = 2;
    localparam int CAP_OFS = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through read port, sync active-high rst.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data (0 while empty), full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign do_rd = rd_en && !empty;
    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a MAC engine: operand stream in (s_*),
// slice pins out (dsp_*), P read back, one {sum,len} result per vector (m_*).
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int LEN_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OP_W-1:0]  s_a,
    input  logic [OP_W-1:0]  s_b,
    input  logic             s_last,
    output logic [OP_W-1:0]  dsp_a,
    output logic [OP_W-1:0]  dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    input  logic [RES_W-1:0] dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RES_W-1:0] m_data,
    output logic [LEN_W-1:0] m_len,
    output logic             busy
);

    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int FW = RES_W + LEN_W;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic             accept;
    logic             acc_last;
    logic             pop;
    logic             first_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [CW-1:0]    credits_q;

    // Tag pipe: index k describes the beat whose issue cycle was k cycles ago.
    logic [CAP_OFS:0] pv_q;
    logic [CAP_OFS:0] pl_q;
    logic [LEN_W-1:0] plen_q [CAP_OFS+1];
    logic             pf_q;

    logic             cap;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_rd;

    assign s_ready  = !RST && (credits_q != '0);
    assign accept   = s_valid && s_ready;
    assign acc_last = accept && s_last;
    assign pop      = m_valid && m_ready;
    assign cnt_inc  = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_W'(1);

    assign dsp_cea      = !RST;
    assign dsp_ceb      = !RST;
    assign dsp_cem      = !RST;
    assign dsp_ceopmode = !RST;

    assign cap = pv_q[CAP_OFS] && pl_q[CAP_OFS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            first_q    <= 1'b1;
            cnt_q      <= '0;
            credits_q  <= CW'(RES_DEPTH);
            pv_q       <= '0;
            pl_q       <= '0;
            pf_q       <= 1'b0;
            for (int k = 0; k <= CAP_OFS; k++) plen_q[k] <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= '0;
            dsp_cep    <= 1'b0;
        end else begin
            dsp_a <= accept ? s_a : '0;
            dsp_b <= accept ? s_b : '0;

            pv_q      <= {pv_q[CAP_OFS-1:0], accept};
            pl_q      <= {pl_q[CAP_OFS-1:0], s_last};
            // Only the opmode stage needs the first tag.
            pf_q      <= first_q;
            plen_q[0] <= cnt_inc;
            for (int k = 1; k <= CAP_OFS; k++) plen_q[k] <= plen_q[k-1];

            if (pv_q[OPM_OFS-1])
                dsp_opmode <= pf_q ? OPM_FIRST : OPM_ACC;
            dsp_cep <= pv_q[CEP_OFS-1];

            if (accept) begin
                first_q <= s_last;
                cnt_q   <= s_last ? '0 : cnt_inc;
            end

            // Credit reserved at last-beat accept, returned on pop.
            case ({acc_last, pop})
                2'b10:   credits_q <= credits_q - CW'(1);
                2'b01:   credits_q <= credits_q + CW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (cap && (!fifo_full || pop)),
        .wr_data ({dsp_p, plen_q[CAP_OFS]}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid         = !fifo_empty;
    assign {m_data, m_len} = fifo_rd;
    assign busy            = (|pv_q) || !fifo_empty;

endmodule
